write_back_buffer: RTL
======================

Name: write_back_buffer

Overview:
- Posted write buffer between the L1 cache and main RAM.
- Accepts dirty-line evictions (address plus data) from the cache in one cycle and drains them to RAM in FIFO order through a request/acknowledge handshake.
- Coalesces repeat writes to the same address and forwards pending data to cache read misses, so the cache never reads stale RAM contents.

Parameters:
- DEPTH, 4, number of buffer entries (power of two, at least 2)
- ADDR_W, 8, address width
- DATA_W, 8, data word width

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- evictValid  in  1  cache presents an eviction this cycle
- evictAddress  in  ADDR_W  address of evicted word
- evictData  in  DATA_W  evicted data
- evictReady  out  1  buffer can accept; equals !full
- lookupAddress  in  ADDR_W  address of the cache read miss
- lookupHit  out  1  lookupAddress matches a valid entry (combinational)
- lookupData  out  DATA_W  data of the youngest matching entry; 0 when no hit
- ramWriteEnable  out  1  write request to RAM, registered
- ramAddress  out  ADDR_W  RAM write address, registered
- ramData  out  DATA_W  RAM write data, registered
- ramAck  in  1  RAM accepted the write this cycle
- count  out  clog2(DEPTH+1)  number of valid entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset (asynchronous, active-low):
  - All entries invalid; pointers and count = 0.
  - FSM = IDLE.
  - ramWriteEnable, ramAddress, ramData = 0.
  - lookupHit = 0, lookupData = 0; empty = 1, full = 0, evictReady = 1.
  - Taking effect mid-WRITE drops the request immediately; pending entries are discarded.
- Storage:
  - Circular FIFO with head and tail pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
  - Each entry holds a valid bit, an address and data.
- Push (evictValid && evictReady at the edge):
  - If an existing entry's address matches evictAddress, that entry's data is overwritten in place (coalesce) and count is unchanged.
  - Otherwise the eviction is written at tail; tail and count increment.
  - The locked head (the entry being written while in WRITE) is excluded from matching. A match only on the locked head appends a new entry.
  - At most one entry matches by construction.
- evictValid while full: ignored; no state change, even if the address would coalesce.
- Forwarding:
  - lookupHit/lookupData are combinational over valid entries, including the locked head.
  - A push in the same cycle is not visible until the following cycle.
- Drain FSM:
  - IDLE: if !empty, load ramAddress/ramData from head, set ramWriteEnable = 1, go to WRITE. ramAck in IDLE is ignored.
  - WRITE: hold ramWriteEnable, ramAddress and ramData stable until ramAck.
    - On ramAck, pop head (head+1, count-1).
    - If entries remain after the pop (excluding a simultaneous push), load the next head and stay in WRITE. This gives back-to-back writes with ramWriteEnable continuously high.
    - Otherwise clear ramWriteEnable and go to IDLE.
- Latency: an eviction pushed into an empty buffer at edge N gives ramWriteEnable = 1 after edge N+1. Minimum occupancy is 2 cycles with ramAck tied high.
- Simultaneous push and pop: count unchanged. A push into a full buffer is still refused even if a pop occurs in the same cycle, because evictReady depends only on count.
- Ordering: RAM sees writes in order of first allocation. Coalesced data takes the allocation slot of the original entry.

Test Plan:
1. Assert reset with ramAck = 0, then release -> count = 0, empty = 1, full = 0, evictReady = 1, ramWriteEnable = 0, lookupHit = 0.
2. Push addr 0x02 data 0x01 at edge N, hold ramAck = 0 -> after N+1 ramWriteEnable = 1, ramAddress = 0x02, ramData = 0x01, stable for 3 cycles. Pulse ramAck -> next edge ramWriteEnable = 0, empty = 1.
3. ramAck = 0; push (0x00,0x05), (0x01,0x03), (0x02,0x01), (0x03,0x00), then (0x04,0x09) -> full = 1, evictReady = 0, 0x04 dropped. Then ramAck = 1 -> four consecutive RAM writes in order 0x00..0x03 with no ramWriteEnable gap, then empty = 1.
4. Head 0x00 locked in WRITE; push (0x01,0x03) then (0x01,0x07) -> count = 2, RAM receives 0x01 once with data 0x07. Pushing (0x00,0x0A) while 0x00 is locked -> count increments and 0x00 is written twice (0x05 then 0x0A).
5. Buffer holds (0x03,0x05), ramAck = 0 -> lookupAddress 0x03 gives lookupHit = 1, lookupData = 0x05; lookupAddress 0x04 gives lookupHit = 0, lookupData = 0x00.
6. Three entries pending, ramWriteEnable = 1; assert reset between clock edges -> ramWriteEnable = 0 immediately, count = 0. After release, no RAM write occurs without a new push.

Source files
------------

// File: rtl/write_back_buffer_if.sv
// write_back_buffer_if: bus bundle for the posted write buffer.
//   Cache side : evictValid/evictAddress/evictData -> evictReady,
//                lookupAddress -> lookupHit/lookupData
//   RAM side   : ramWriteEnable/ramAddress/ramData -> ramAck
//   Status     : count, full, empty
// slave modport is the buffer itself; master is whatever drives it.
interface write_back_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              evictValid;
  logic [ADDR_W-1:0] evictAddress;
  logic [DATA_W-1:0] evictData;
  logic              evictReady;
  logic [ADDR_W-1:0] lookupAddress;
  logic              lookupHit;
  logic [DATA_W-1:0] lookupData;
  logic              ramWriteEnable;
  logic [ADDR_W-1:0] ramAddress;
  logic [DATA_W-1:0] ramData;
  logic              ramAck;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport slave (
    input  evictValid, evictAddress, evictData, lookupAddress, ramAck,
    output evictReady, lookupHit, lookupData, ramWriteEnable, ramAddress,
           ramData, count, full, empty
  );

  modport master (
    output evictValid, evictAddress, evictData, lookupAddress, ramAck,
    input  evictReady, lookupHit, lookupData, ramWriteEnable, ramAddress,
           ramData, count, full, empty
  );
endinterface

// File: rtl/write_back_buffer.sv
// write_back_buffer: posted write buffer between L1 and main RAM.
//   clock/reset : rising-edge clock, async active-low reset
//   bus (slave) : eviction push port, read-miss forwarding lookup,
//                 registered RAM write request with ack, occupancy status
// Evictions are queued in a circular FIFO and drained in allocation order.
// A repeat write to a queued address overwrites that entry in place, except
// the head currently being written to RAM, which is locked.
module write_back_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  write_back_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              full, empty;
  logic              push, coalesce, append;
  logic [DEPTH-1:0]  locked, push_match, look_match;
  logic [PTR_W-1:0]  match_idx;

  logic              load, pop, clr;
  logic [PTR_W-1:0]  load_ptr;
  logic [DATA_W-1:0] load_data;

  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);

  // Per-entry address compare. The locked head never takes a coalesce, but
  // it still forwards to lookups.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign locked[i]     = (state_q == WRITE) && (head_q == PTR_W'(i));
    assign push_match[i] = vld_q[i] && !locked[i] && (addr_q[i] == bus.evictAddress);
    assign look_match[i] = vld_q[i] && (addr_q[i] == bus.lookupAddress);
  end

  assign push     = bus.evictValid && !full;
  assign coalesce = push && (|push_match);
  assign append   = push && !coalesce;

  always_comb begin
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (push_match[i]) match_idx = PTR_W'(i);
  end

  // Youngest match wins: an unlocked match is always newer than the locked
  // head, so it overrides the head's data.
  always_comb begin
    bus.lookupData = '0;
    for (int i = 0; i < DEPTH; i++)
      if (look_match[i] && locked[i]) bus.lookupData = data_q[i];
    for (int i = 0; i < DEPTH; i++)
      if (look_match[i] && !locked[i]) bus.lookupData = data_q[i];
  end
  assign bus.lookupHit = |look_match;

  // Drain FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    pop      = 1'b0;
    clr      = 1'b0;
    load_ptr = head_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.ramAck) begin
          pop = 1'b1;
          if (cnt_q > CNT_W'(1)) begin
            load     = 1'b1;
            load_ptr = head_q + PTR_W'(1);
          end else begin
            clr     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An entry being coalesced in the same cycle it is loaded for RAM must send
  // the new data, otherwise the update would be lost once it becomes locked.
  assign load_data = (coalesce && (match_idx == load_ptr)) ? bus.evictData
                                                           : data_q[load_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else if (load) begin
      ram_we_q   <= 1'b1;
      ram_addr_q <= addr_q[load_ptr];
      ram_data_q <= load_data;
    end else if (clr) begin
      ram_we_q   <= 1'b0;
    end
  end

  // FIFO control
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      // tail can only equal head when full, and full refuses pushes
      if (append) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_W'(1);
      end
      case ({append, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry payload needs no reset; validity is tracked by vld_q.
  always_ff @(posedge clock) begin
    if (append) begin
      addr_q[tail_q] <= bus.evictAddress;
      data_q[tail_q] <= bus.evictData;
    end else if (coalesce) begin
      data_q[match_idx] <= bus.evictData;
    end
  end

  assign bus.evictReady     = !full;
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.count          = cnt_q;
  assign bus.ramWriteEnable = ram_we_q;
  assign bus.ramAddress     = ram_addr_q;
  assign bus.ramData        = ram_data_q;
endmodule
